// File: rtl/lstm_gate_sequencer.sv
// Sequencer for the LSTM MAC datapath: runs NUM_GATES gate passes of ROWS rows each and
// writes every row result to the result buffer. Optional watchdog under `LSTM_SEQ_TIMEOUT_EN.
module lstm_gate_sequencer #(
    parameter int NUM_GATES = 4,
    parameter int ROWS      = 16,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 19,
    parameter int W_STRIDE  = 512,
    parameter int TMO_CYC   = 1024
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mac_busy,
    output logic              mac_clear,
    output logic [1:0]        gate_sel,
    output logic [ADDR_W-1:0] w_base_addr,
    input  logic              mac_row_done,
    input  logic [DATA_W-1:0] mac_g_out,
    output logic              res_wr_en,
    output logic [ADDR_W-1:0] res_wr_addr,
    output logic [DATA_W-1:0] res_wr_data,
    output logic              err
);

    localparam int                ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [1:0]        LAST_GATE = 2'(NUM_GATES - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ROWS_A    = ADDR_W'(ROWS);
    localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(W_STRIDE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_WRITE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t            state;
    logic [ROW_W-1:0]  row;
    logic              row_done_q;
    logic              row_done_qq;
    logic [DATA_W-1:0] g_q;
    logic              row_edge;

    // Edge is taken between the two registered copies, so a level already high on RUN entry never counts.
    assign row_edge = row_done_q & ~row_done_qq;

`ifdef LSTM_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state       <= S_IDLE;
            row         <= '0;
            row_done_q  <= 1'b0;
            row_done_qq <= 1'b0;
            g_q         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mac_busy    <= 1'b0;
            mac_clear   <= 1'b0;
            gate_sel    <= '0;
            w_base_addr <= '0;
            res_wr_en   <= 1'b0;
            res_wr_addr <= '0;
            res_wr_data <= '0;
`ifdef LSTM_SEQ_TIMEOUT_EN
            err         <= 1'b0;
            tmo_cnt     <= '0;
`endif
        end else begin
            row_done_q  <= mac_row_done;
            row_done_qq <= row_done_q;
            g_q         <= mac_g_out;
            res_wr_en   <= 1'b0;
            mac_clear   <= 1'b0;
            done        <= 1'b0;
`ifdef LSTM_SEQ_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_LAUNCH;
                        busy        <= 1'b1;
                        gate_sel    <= '0;
                        row         <= '0;
                        w_base_addr <= '0;
`ifdef LSTM_SEQ_TIMEOUT_EN
                        err         <= 1'b0;
`endif
                    end
                end
                S_LAUNCH: begin
                    mac_busy <= 1'b1;
                    state    <= S_RUN;
                end
                S_RUN: begin
                    if (row_edge) begin
                        res_wr_en   <= 1'b1;
                        res_wr_addr <= ADDR_W'(gate_sel) * ROWS_A + ADDR_W'(row);
                        res_wr_data <= g_q;
                        state       <= S_WRITE;
                    end
`ifdef LSTM_SEQ_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
                        // Abandon the job through CLEAR so the engine still sees its clear pulse.
                        err       <= 1'b1;
                        mac_busy  <= 1'b0;
                        mac_clear <= 1'b1;
                        state     <= S_CLEAR;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                S_WRITE: begin
                    if (row == LAST_ROW) begin
                        mac_busy  <= 1'b0;
                        mac_clear <= 1'b1;
                        state     <= S_CLEAR;
                    end else begin
                        row   <= row + ROW_W'(1);
                        state <= S_RUN;
                    end
                end
                S_CLEAR: begin
                    row <= '0;
`ifdef LSTM_SEQ_TIMEOUT_EN
                    if (gate_sel == LAST_GATE || err) begin
`else
                    if (gate_sel == LAST_GATE) begin
`endif
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        gate_sel    <= gate_sel + 2'd1;
                        w_base_addr <= ADDR_W'(gate_sel + 2'd1) * STRIDE_A;
                        state       <= S_LAUNCH;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_gate_sequencer.sv
// Directed testbench for lstm_gate_sequencer: a behavioural MAC model returns rows and a
// write monitor checks every result-buffer write against the expected address and data.
module tb_lstm_gate_sequencer;

    localparam int ROWS   = 16;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 19;

    logic              clk = 1'b0;
    logic              reset_b = 1'b0;
    logic              start = 1'b0;
    logic              mac_row_done = 1'b0;
    logic [DATA_W-1:0] mac_g_out = '0;
    logic              busy, done, mac_busy, mac_clear, res_wr_en, err;
    logic [1:0]        gate_sel;
    logic [ADDR_W-1:0] w_base_addr, res_wr_addr;
    logic [DATA_W-1:0] res_wr_data;

    int vectors = 0;
    int miscompares = 0;
    int wr_count = 0;
    int done_count = 0;
    int clear_count = 0;
    int exp_addr = 0;
    logic [DATA_W-1:0] exp_q[$];

    lstm_gate_sequencer #(
        .NUM_GATES(4), .ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .W_STRIDE(512), .TMO_CYC(64)
    ) dut (
        .clk(clk), .reset_b(reset_b), .start(start), .busy(busy), .done(done),
        .mac_busy(mac_busy), .mac_clear(mac_clear), .gate_sel(gate_sel),
        .w_base_addr(w_base_addr), .mac_row_done(mac_row_done), .mac_g_out(mac_g_out),
        .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rowVal(input int i);
        case (i)
            0:       return 19'h3FFFF;
            1:       return 19'h40000;
            2:       return 19'h00000;
            default: return 19'(i * 4099 + 17);
        endcase
    endfunction

    // MAC model: one row result, rising level held a few cycles, with a 2-clock write latency check.
    task automatic applyStimulus(input logic [DATA_W-1:0] val);
        int n = 0;
        while (!mac_busy && n < 64) begin
            tick(1);
            n++;
        end
        checkOutput("row_wait_mac_busy", 32'(mac_busy), 1);
        mac_g_out    = val;
        mac_row_done = 1'b1;
        exp_q.push_back(val);
        tick(1);
        checkOutput("lat_early", 32'(res_wr_en), 0);
        tick(1);
        checkOutput("lat_2clk", 32'(res_wr_en), 1);
        checkOutput("lat_data", 32'(res_wr_data), 32'(val));
        tick(2);
        mac_row_done = 1'b0;
        mac_g_out    = '0;
        tick(4);
    endtask

    task automatic startJob();
        exp_q.delete();
        exp_addr    = 0;
        wr_count    = 0;
        done_count  = 0;
        clear_count = 0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        checkOutput("start_busy", 32'(busy), 1);
        checkOutput("start_gate", 32'(gate_sel), 0);
    endtask

    // Write monitor: every write must follow ascending addresses with the data the model issued.
    always @(negedge clk) begin
        if (reset_b) begin
            if (res_wr_en) begin
                wr_count++;
                checkOutput("wr_addr", 32'(res_wr_addr), 32'(exp_addr[ADDR_W-1:0]));
                if (exp_q.size() == 0) checkOutput("wr_unexpected", 32'(res_wr_data), 32'hDEAD_BEEF);
                else checkOutput("wr_data", 32'(res_wr_data), 32'(exp_q.pop_front()));
                exp_addr++;
            end
            if (done) done_count++;
            if (mac_clear) clear_count++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        // Reset state
        tick(2);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_mac_busy", 32'(mac_busy), 0);
        checkOutput("rst_mac_clear", 32'(mac_clear), 0);
        checkOutput("rst_gate", 32'(gate_sel), 0);
        checkOutput("rst_wbase", 32'(w_base_addr), 0);
        checkOutput("rst_wr_en", 32'(res_wr_en), 0);
        checkOutput("rst_wr_addr", 32'(res_wr_addr), 0);
        checkOutput("rst_wr_data", 32'(res_wr_data), 0);
        checkOutput("rst_err", 32'(err), 0);
        reset_b = 1'b1;
        tick(1);

        // Job 1: full job, boundary row values at rows 0..2
        $display("[TB] job 1: nominal 64-row job");
        startJob();
        checkOutput("launch_mac_busy", 32'(mac_busy), 0);
        tick(1);
        checkOutput("run_mac_busy", 32'(mac_busy), 1);
        checkOutput("run_wbase0", 32'(w_base_addr), 0);
        for (int i = 0; i < 64; i++) begin
            applyStimulus(rowVal(i));
            if (i % ROWS == 0) begin
                checkOutput("gate_sel", 32'(gate_sel), 32'(i / ROWS));
                checkOutput("w_base_addr", 32'(w_base_addr), 32'((i / ROWS) * 512));
            end
        end
        tick(3);
        checkOutput("job1_writes", 32'(wr_count), 64);
        checkOutput("job1_dones", 32'(done_count), 1);
        checkOutput("job1_clears", 32'(clear_count), 4);
        checkOutput("job1_busy_after", 32'(busy), 0);
        checkOutput("job1_mac_busy_after", 32'(mac_busy), 0);
        checkOutput("job1_err", 32'(err), 0);

        // Job 2: stale level across gate change, start mid-job and in the DONE cycle
        $display("[TB] job 2: stale row level and ignored starts");
        startJob();
        for (int i = 0; i < 64; i++) begin
            if (i == 15) begin
                mac_g_out    = rowVal(i);
                mac_row_done = 1'b1;
                exp_q.push_back(rowVal(i));
                tick(2);
                checkOutput("stale_last_write", 32'(res_wr_en), 1);
                n = 0;
                while (!(mac_busy && gate_sel == 2'd1) && n < 32) begin
                    tick(1);
                    n++;
                end
                checkOutput("stale_gate1", 32'(gate_sel), 1);
                tick(6);
                checkOutput("stale_nowrite", 32'(wr_count), 16);
                checkOutput("stale_wr_en", 32'(res_wr_en), 0);
                mac_row_done = 1'b0;
                tick(3);
            end else if (i == 63) begin
                mac_g_out    = rowVal(i);
                mac_row_done = 1'b1;
                exp_q.push_back(rowVal(i));
                tick(2);
                checkOutput("last_write", 32'(res_wr_en), 1);
                tick(1);
                checkOutput("last_clear", 32'(mac_clear), 1);
                checkOutput("last_clear_mac_busy", 32'(mac_busy), 0);
                tick(1);
                checkOutput("done_pulse", 32'(done), 1);
                start = 1'b1;
                tick(1);
                start = 1'b0;
                mac_row_done = 1'b0;
                checkOutput("done_pulse_len", 32'(done), 0);
                checkOutput("busy_after_done", 32'(busy), 0);
                tick(4);
                checkOutput("done_start_ignored", 32'(busy), 0);
            end else begin
                if (i == 37) begin
                    start = 1'b1;
                    tick(1);
                    start = 1'b0;
                    checkOutput("midjob_busy", 32'(busy), 1);
                    checkOutput("midjob_gate", 32'(gate_sel), 2);
                end
                applyStimulus(rowVal(i));
            end
        end
        checkOutput("job2_writes", 32'(wr_count), 64);
        checkOutput("job2_dones", 32'(done_count), 1);
        checkOutput("job2_clears", 32'(clear_count), 4);

        // Job 3: async reset in gate 2 row 5, then a fresh job restarts at address 0
        $display("[TB] job 3: reset mid-job");
        startJob();
        for (int i = 0; i < 37; i++) applyStimulus(rowVal(i + 100));
        checkOutput("pre_rst_gate", 32'(gate_sel), 2);
        reset_b = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_mac_busy", 32'(mac_busy), 0);
        checkOutput("midrst_gate", 32'(gate_sel), 0);
        checkOutput("midrst_wbase", 32'(w_base_addr), 0);
        checkOutput("midrst_wr_addr", 32'(res_wr_addr), 0);
        checkOutput("midrst_wr_data", 32'(res_wr_data), 0);
        checkOutput("midrst_writes", 32'(wr_count), 37);
        tick(2);
        reset_b = 1'b1;
        tick(3);
        checkOutput("midrst_no_done", 32'(done_count), 0);

        $display("[TB] job 4: restart after reset");
        startJob();
        for (int i = 0; i < 64; i++) applyStimulus(rowVal(63 - i));
        tick(3);
        checkOutput("job4_writes", 32'(wr_count), 64);
        checkOutput("job4_dones", 32'(done_count), 1);
        checkOutput("job4_busy_after", 32'(busy), 0);

`ifdef LSTM_SEQ_TIMEOUT_EN
        // Job 5: stall at gate 1 row 3 trips the watchdog
        $display("[TB] job 5: watchdog");
        startJob();
        for (int i = 0; i < 19; i++) applyStimulus(rowVal(i));
        n = 0;
        while (done_count == 0 && n < 400) begin
            tick(1);
            n++;
        end
        tick(2);
        checkOutput("tmo_dones", 32'(done_count), 1);
        checkOutput("tmo_err", 32'(err), 1);
        checkOutput("tmo_writes", 32'(wr_count), 19);
        checkOutput("tmo_clears", 32'(clear_count), 2);
        checkOutput("tmo_busy", 32'(busy), 0);
        checkOutput("tmo_mac_busy", 32'(mac_busy), 0);
        startJob();
        checkOutput("tmo_err_cleared", 32'(err), 0);
        reset_b = 1'b0;
        tick(2);
        reset_b = 1'b1;
        tick(1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
